// File: rtl/plic_sched_pkg.sv
// -----------------------------------------------------------------------------
// plic_sched_pkg
// Shared defaults, types and constants for the PLIC gateway / claim-complete
// scheduler (plic_target_sched) and its per-target arbiter (plic_target_arb).
//   N_SRC  : number of interrupt sources (source s has interrupt ID s+1)
//   N_TGT  : number of targets (hart contexts)
//   PRIO_W : priority / threshold width
//   ID_W   : claim ID width, 2**ID_W must exceed N_SRC
// -----------------------------------------------------------------------------
package plic_sched_pkg;

    localparam int N_SRC  = 3;
    localparam int N_TGT  = 4;
    localparam int PRIO_W = 3;
    localparam int ID_W   = 2;

    typedef logic [PRIO_W-1:0] prio_t;
    typedef logic [ID_W-1:0]   id_t;

    // Interrupt ID 0 is reserved for "no interrupt".
    localparam id_t NO_IRQ = '0;

endpackage : plic_sched_pkg

// File: rtl/plic_target_arb.sv
// -----------------------------------------------------------------------------
// plic_target_arb
// Purely combinational arbiter for one target: picks the enabled candidate
// source with the highest priority strictly above the target threshold.
// Ties go to the lowest interrupt ID.
// Ports:
//   cand      : sources that are pending and not in service (next state)
//   ie        : this target's enable bits
//   prio      : per-source priority
//   threshold : this target's threshold
//   id        : winning interrupt ID (source index + 1), NO_IRQ if none
// -----------------------------------------------------------------------------
module plic_target_arb
    import plic_sched_pkg::*;
#(
    parameter int N_SRC  = plic_sched_pkg::N_SRC,
    parameter int PRIO_W = plic_sched_pkg::PRIO_W,
    parameter int ID_W   = plic_sched_pkg::ID_W
) (
    input  logic [N_SRC-1:0]             cand,
    input  logic [N_SRC-1:0]             ie,
    input  logic [N_SRC-1:0][PRIO_W-1:0] prio,
    input  logic [PRIO_W-1:0]            threshold,
    output logic [ID_W-1:0]              id
);

    logic [PRIO_W-1:0] best_prio;

    // Seeding the running maximum with the threshold folds the threshold
    // compare into the search; the strict '>' keeps the lowest ID on ties
    // and also rejects priority 0.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no
        // path leaves it holding a stale value and no latch is inferred.
        best_prio = threshold;
        id        = ID_W'(NO_IRQ);
        for (int s = 0; s < N_SRC; s++) begin
            if (cand[s] && ie[s] && (prio[s] > best_prio)) begin
                best_prio = prio[s];
                id        = ID_W'(s + 1);
            end
        end
    end

endmodule : plic_target_arb

// File: rtl/plic_target_sched.sv
// -----------------------------------------------------------------------------
// plic_target_sched
// PLIC interrupt gateway plus per-target claim/complete scheduler. Samples
// level (optionally edge) sources into pending bits, registers per-target
// arbitration winners, grants claims (lowest target wins a collision) and
// retires completes.
// Configuration macro: PLIC_EDGE_TRIG_EN adds le_i and per-source edge
// detection; without it every source is level-triggered.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   le_i           : (PLIC_EDGE_TRIG_EN only) 1 = edge-triggered source
//   irq_src_i      : interrupt source lines
//   prio_i         : per-source priority (0 = never interrupts)
//   ie_i           : per-target source enables
//   threshold_i    : per-target threshold
//   claim_re_i     : per-target claim strobe
//   complete_we_i  : per-target complete strobe
//   complete_id_i  : per-target ID written on complete
//   ip_o           : pending bits
//   claim_id_o     : per-target claimed ID (0 unless granted)
//   irq_o          : per-target interrupt request
// -----------------------------------------------------------------------------
module plic_target_sched
    import plic_sched_pkg::*;
#(
    parameter int N_SRC  = plic_sched_pkg::N_SRC,
    parameter int N_TGT  = plic_sched_pkg::N_TGT,
    parameter int PRIO_W = plic_sched_pkg::PRIO_W,
    parameter int ID_W   = plic_sched_pkg::ID_W
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
`ifdef PLIC_EDGE_TRIG_EN
    input  logic [N_SRC-1:0]             le_i,
`endif
    input  logic [N_SRC-1:0]             irq_src_i,
    input  logic [N_SRC-1:0][PRIO_W-1:0] prio_i,
    input  logic [N_TGT-1:0][N_SRC-1:0]  ie_i,
    input  logic [N_TGT-1:0][PRIO_W-1:0] threshold_i,
    input  logic [N_TGT-1:0]             claim_re_i,
    input  logic [N_TGT-1:0]             complete_we_i,
    input  logic [N_TGT-1:0][ID_W-1:0]   complete_id_i,
    output logic [N_SRC-1:0]             ip_o,
    output logic [N_TGT-1:0][ID_W-1:0]   claim_id_o,
    output logic [N_TGT-1:0]             irq_o
);

    logic [N_SRC-1:0]           pend_q, pend_d, pend_set;
    logic [N_SRC-1:0]           insvc_q, insvc_d;
    logic [N_SRC-1:0]           claimed, completed;
    logic [N_TGT-1:0]           grant;
    logic [N_TGT-1:0][ID_W-1:0] best_q, best_d;

`ifdef PLIC_EDGE_TRIG_EN
    logic [N_SRC-1:0]           prev_q;
`endif

    // ---------------------------------------------------------------- gateway
    // Level sources re-pend only once they are neither pending nor in service.
    // Edge sources latch a rising edge even while in service (arbitration
    // keeps them ineligible until complete); an edge seen while already
    // pending is dropped.
    always_comb begin
        pend_set = '0;
        for (int s = 0; s < N_SRC; s++) begin
`ifdef PLIC_EDGE_TRIG_EN
            if (le_i[s]) begin
                pend_set[s] = irq_src_i[s] & ~prev_q[s] & ~pend_q[s];
            end else begin
                pend_set[s] = irq_src_i[s] & ~pend_q[s] & ~insvc_q[s];
            end
`else
            pend_set[s] = irq_src_i[s] & ~pend_q[s] & ~insvc_q[s];
`endif
        end
    end

    // ------------------------------------------------------------ claim grant
    // A target is granted when it claims a real ID and no lower-indexed target
    // claims the same ID in this cycle.
    always_comb begin
        grant = '0;
        for (int t = 0; t < N_TGT; t++) begin
            grant[t] = claim_re_i[t] && (best_q[t] != ID_W'(NO_IRQ));
            for (int u = 0; u < t; u++) begin
                if (claim_re_i[u] && (best_q[u] == best_q[t])) begin
                    grant[t] = 1'b0;
                end
            end
        end
    end

    // Map granted claims and valid completes onto sources. A complete only
    // counts for an in-range ID that is currently in service.
    always_comb begin
        claimed   = '0;
        completed = '0;
        for (int s = 0; s < N_SRC; s++) begin
            for (int t = 0; t < N_TGT; t++) begin
                if (grant[t] && (best_q[t] == ID_W'(s + 1))) begin
                    claimed[s] = 1'b1;
                end
                if (complete_we_i[t] && (complete_id_i[t] == ID_W'(s + 1)) && insvc_q[s]) begin
                    completed[s] = 1'b1;
                end
            end
        end
    end

    assign pend_d  = (pend_q | pend_set) & ~claimed;
    assign insvc_d = (insvc_q & ~completed) | claimed;

    // ------------------------------------------------------------ arbitration
    // Arbitrating on next-state pend/insvc means a source claimed this cycle
    // is already gone from best_q on the following cycle.
    for (genvar t = 0; t < N_TGT; t++) begin : g_arb
        plic_target_arb #(
            .N_SRC  (N_SRC),
            .PRIO_W (PRIO_W),
            .ID_W   (ID_W)
        ) u_arb (
            .cand      (pend_d & ~insvc_d),
            .ie        (ie_i[t]),
            .prio      (prio_i),
            .threshold (threshold_i[t]),
            .id        (best_d[t])
        );
    end

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst_i) begin
            pend_q  <= '0;
            insvc_q <= '0;
            best_q  <= '0;
        end else begin
            pend_q  <= pend_d;
            insvc_q <= insvc_d;
            best_q  <= best_d;
        end
    end

`ifdef PLIC_EDGE_TRIG_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= '0;
        end else begin
            prev_q <= irq_src_i;
        end
    end
`endif

    // ---------------------------------------------------------------- outputs
    assign ip_o = pend_q;

    always_comb begin
        claim_id_o = '0;
        irq_o      = '0;
        for (int t = 0; t < N_TGT; t++) begin
            claim_id_o[t] = grant[t] ? best_q[t] : ID_W'(NO_IRQ);
            irq_o[t]      = (best_q[t] != ID_W'(NO_IRQ));
        end
    end

endmodule : plic_target_sched

// File: tb/tb_plic_target_sched.sv
// -----------------------------------------------------------------------------
// tb_plic_target_sched
// Directed self-checking bench for plic_target_sched (default parameters:
// 3 sources, 4 targets, 3-bit priority, 2-bit ID). Inputs change and outputs
// are sampled 1 time unit after the rising edge. Edge-trigger scenario is
// compiled in only when PLIC_EDGE_TRIG_EN is defined.
// -----------------------------------------------------------------------------
module tb_plic_target_sched;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [2:0]       irq_src;
    logic [2:0][2:0]  prio;
    logic [3:0][2:0]  ie;
    logic [3:0][2:0]  threshold;
    logic [3:0]       claim_re;
    logic [3:0]       complete_we;
    logic [3:0][1:0]  complete_id;
    logic [2:0]       ip;
    logic [3:0][1:0]  claim_id;
    logic [3:0]       irq;
`ifdef PLIC_EDGE_TRIG_EN
    logic [2:0]       le;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    plic_target_sched dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
`ifdef PLIC_EDGE_TRIG_EN
        .le_i          (le),
`endif
        .irq_src_i     (irq_src),
        .prio_i        (prio),
        .ie_i          (ie),
        .threshold_i   (threshold),
        .claim_re_i    (claim_re),
        .complete_we_i (complete_we),
        .complete_id_i (complete_id),
        .ip_o          (ip),
        .claim_id_o    (claim_id),
        .irq_o         (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        irq_src     = '0;
        prio        = '0;
        ie          = '0;
        threshold   = '0;
        claim_re    = '0;
        complete_we = '0;
        complete_id = '0;
`ifdef PLIC_EDGE_TRIG_EN
        le          = '0;
`endif
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        do_reset();
        #1;
        check("reset_ip", ip, 3'b000);
        check("reset_irq", irq, 4'b0000);
        check("reset_claim_id", claim_id, 8'h00);

        // ---- single source to irq, claim, complete with line still high
        prio[0] = 3'd3; prio[1] = 3'd2; prio[2] = 3'd1;
        ie[0] = 3'b111;
        irq_src = 3'b001;
        tick();
        check("single_ip", ip, 3'b001);
        check("single_irq", irq, 4'b0001);
        claim_re[0] = 1'b1;
        #1;
        check("single_claim_id", claim_id[0], 2'd1);
        tick();
        claim_re = '0;
        #1;
        check("single_ip_after_claim", ip, 3'b000);
        check("single_irq_after_claim", irq, 4'b0000);
        complete_we[0] = 1'b1; complete_id[0] = 2'd1;
        tick();
        complete_we = '0;
        check("complete_ip_edge1", ip, 3'b000);
        tick();
        check("complete_ip_edge2", ip, 3'b001);
        check("complete_irq_edge2", irq, 4'b0001);

        // ---- priority and tie-break with back-to-back claims
        do_reset();
        prio[0] = 3'd2; prio[1] = 3'd5; prio[2] = 3'd5;
        ie[0] = 3'b111;
        irq_src = 3'b111;
        tick();
        check("prio_ip", ip, 3'b111);
        claim_re[0] = 1'b1;
        #1;
        check("prio_claim1", claim_id[0], 2'd2);
        tick();
        check("prio_ip_after1", ip, 3'b101);
        check("prio_claim2", claim_id[0], 2'd3);
        tick();
        check("prio_ip_after2", ip, 3'b001);
        check("prio_claim3", claim_id[0], 2'd1);
        claim_re = '0;

        // ---- threshold
        do_reset();
        prio[1] = 3'd2;
        ie[1] = 3'b010;
        threshold[1] = 3'd2;
        irq_src = 3'b010;
        tick();
        tick();
        check("thr_ip", ip, 3'b010);
        check("thr_irq_blocked", irq, 4'b0000);
        threshold[1] = 3'd1;
        #1;
        check("thr_irq_not_yet", irq, 4'b0000);
        tick();
        check("thr_irq_open", irq, 4'b0010);

        // ---- claim collision
        do_reset();
        prio[0] = 3'd1;
        ie[0] = 3'b001; ie[2] = 3'b001;
        irq_src = 3'b001;
        tick();
        check("coll_irq", irq, 4'b0101);
        claim_re = 4'b0101;
        #1;
        check("coll_claim_t0", claim_id[0], 2'd1);
        check("coll_claim_t2", claim_id[2], 2'd0);
        tick();
        claim_re = '0;
        check("coll_ip_next", ip, 3'b000);
        check("coll_irq_next", irq, 4'b0000);

        // ---- ignored completes (ID 3 not in service, ID 0)
        complete_we = 4'b1010;
        complete_id[1] = 2'd3;
        complete_id[3] = 2'd0;
        tick();
        complete_we = '0;
        tick();
        check("bad_complete_ip", ip, 3'b000);
        check("bad_complete_irq", irq, 4'b0000);

        // ---- valid complete from another target
        complete_we[3] = 1'b1; complete_id[3] = 2'd1;
        tick();
        complete_we = '0;
        tick();
        check("xtgt_complete_ip", ip, 3'b001);
        check("xtgt_complete_irq", irq, 4'b0101);

        // ---- reset one cycle after a claim
        claim_re = 4'b0100;
        #1;
        check("rst_claim_t2", claim_id[2], 2'd1);
        tick();
        rst_i = 1'b1;
        tick();
        check("rst_mid_ip", ip, 3'b000);
        check("rst_mid_irq", irq, 4'b0000);
        check("rst_mid_claim_id", claim_id, 8'h00);
        rst_i = 1'b0;
        claim_re = '0;
        tick();
        check("post_rst_ip", ip, 3'b001);
        check("post_rst_irq", irq, 4'b0101);

`ifdef PLIC_EDGE_TRIG_EN
        // ---- edge source re-pends while in service, claimable after complete
        do_reset();
        le = 3'b001;
        prio[0] = 3'd1;
        ie[0] = 3'b001;
        irq_src = 3'b001;
        tick();
        irq_src = 3'b000;
        check("edge_ip", ip, 3'b001);
        check("edge_irq", irq, 4'b0001);
        claim_re[0] = 1'b1;
        tick();
        claim_re = '0;
        check("edge_ip_claimed", ip, 3'b000);
        irq_src = 3'b001;
        tick();
        irq_src = 3'b000;
        check("edge_repend_ip", ip, 3'b001);
        check("edge_repend_irq", irq, 4'b0000);
        claim_re[0] = 1'b1;
        #1;
        check("edge_claim_blocked", claim_id[0], 2'd0);
        claim_re = '0;
        complete_we[0] = 1'b1; complete_id[0] = 2'd1;
        tick();
        complete_we = '0;
        check("edge_after_complete_irq", irq, 4'b0001);
        claim_re[0] = 1'b1;
        #1;
        check("edge_claim_after_complete", claim_id[0], 2'd1);
        claim_re = '0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_plic_target_sched

// File: doc/plic_target_sched.md
# plic_target_sched

Interrupt gateway and per-target claim/complete scheduler for the PLIC. It samples external interrupt sources into pending bits and arbitrates, for each hart context, the highest-priority enabled pending source above that target's threshold. It also sequences the claim/complete handshake. It sits behind `plic_regs`: it consumes the prio/ie/threshold register values and the cc read/write strobes, and it returns `ip` and the claim ID that `plic_regs` presents on a cc read.

## Interface
Parameters:
- `N_SRC`, default 3: number of interrupt sources. Source index s has interrupt ID s+1. ID 0 means "no interrupt".
- `N_TGT`, default 4: number of targets (hart contexts).
- `PRIO_W`, default 3: priority and threshold width.
- `ID_W`, default 2: claim ID width. Must satisfy 2^ID_W > N_SRC.

Ports:
- `clk_i` in, 1: clock. Single clock domain.
- `rst_i` in, 1: reset. Synchronous, active-high.
- `irq_src_i` in, N_SRC: level interrupt sources, already synchronous to `clk_i`.
- `prio_i` in, N_SRC×PRIO_W: per-source priority. 0 means never interrupts.
- `ie_i` in, N_TGT×N_SRC: per-target enable bits.
- `threshold_i` in, N_TGT×PRIO_W: per-target threshold.
- `claim_re_i` in, N_TGT: claim strobe, driven from `cc_re_o`.
- `complete_we_i` in, N_TGT: complete strobe, driven from `cc_we_o`.
- `complete_id_i` in, N_TGT×ID_W: ID written on complete, driven from `cc_o`.
- `ip_o` out, N_SRC: pending bits, fed to `ip_i`.
- `claim_id_o` out, N_TGT×ID_W: ID returned on a claim read, fed to `cc_i`.
- `irq_o` out, N_TGT: interrupt request to each hart context.

## Operation
- **Per-source state.** Each source has `pend_q` and `insvc_q`.
  - Level gateway: `pend` is set when `irq_src_i[s]`=1, `pend_q`=0 and `insvc_q`=0.
  - `ip_o` = `pend_q`.
- **Arbitration (per target).**
  - A source is eligible when: next-state pending is 1, `ie_i`=1, `insvc` is 0, and `prio_i` > `threshold_i`.
  - The winner is the eligible source with the highest priority. Ties go to the lowest ID.
  - The winner's ID is registered into `best_q[t]`, or 0 if no source is eligible.
  - `irq_o[t]` = (`best_q[t]` != 0).
- **Claim.**
  - When `claim_re_i[t]` is asserted, `claim_id_o[t]` returns `best_q[t]` in the same cycle.
  - On the next edge, that source's `pend` is cleared and its `insvc` is set.
  - A claim when `best_q[t]`=0 returns 0 and changes no state.
- **Claim collision.** If several targets claim the same ID in one cycle, the lowest target index receives the ID. The others read 0 in that cycle.
  - `claim_id_o[t]` = `best_q[t]` masked by these grants (combinational).
- **Complete.**
  - When `complete_we_i[t]` is asserted with an ID in 1..N_SRC whose `insvc` is 1, that `insvc` is cleared at the next edge. Any target may complete any ID.
  - A complete with ID 0, an out-of-range ID, or a non-in-service ID is ignored.
- **Simultaneous events.** A claim and a complete in the same cycle, from the same or different targets, both take effect.
  - Arbitration uses next-state pending/insvc, so a claimed source never reappears in `best_q`.
  - A completed source whose source line is still high re-pends on the edge after the complete.
- **Reset.** Clears all pending, insvc and `best_q`. Behaviour is identical whether reset arrives idle or mid-claim.
  - Reset values: `ip_o`=0, `claim_id_o`=0, `irq_o`=0.

## Timing
- Source rise at edge k: `pend_q`=1 and `best_q`/`irq_o` updated after edge k+1. That is 1-cycle latency for both `ip_o` and `irq_o`.
- A change to `prio_i`, `ie_i` or `threshold_i` is reflected in `irq_o` after 1 edge.
- Claim in cycle c: the ID is returned in cycle c. In cycle c+1, `ip_o` is cleared and `best_q` already excludes the claimed source, so back-to-back claims never return a stale ID.
- Complete in cycle c: `insvc` clears at edge c+1. If the source line is still high, `pend` sets at edge c+2 and `irq_o` at edge c+2.

## Configuration
- `PLIC_EDGE_TRIG_EN` defined: adds input port `le_i` (N_SRC). For sources with `le_i[s]`=1, a registered previous-sample flop detects rising edges.
  - A rising edge sets `pend` even while `insvc`=1. The source stays non-eligible until its complete.
  - An edge arriving while `pend`=1 is dropped.
  - Sources with `le_i[s]`=0 behave as level sources.
- `PLIC_EDGE_TRIG_EN` undefined: no `le_i` port, no edge flops. All sources are level-triggered.

## Structure
- Package `plic_sched_pkg`:
  - `N_SRC`, `N_TGT`, `PRIO_W`, `ID_W` defaults.
  - Typedefs `prio_t` and `id_t`.
  - Constant `NO_IRQ` = 0.
- Sub-module `plic_target_arb`, instantiated N_TGT times. Purely combinational: max-priority finder with lowest-ID tie-break and threshold compare.
- Gateway, claim-grant masking and state registers live in the top module.

## Test plan
- **Single source to irq:** prio=3/2/1, `ie[0]`=3'b111, threshold[0]=0, raise src1 → after 1 cycle `ip_o`=3'b001, `irq_o[0]`=1, `claim_id_o[0]`=1.
- **Priority and tie-break:** all sources high, prio={2,5,5} for IDs 1–3 → `best`=2. Claim → returns 2, then `best`=3. Claim → returns 3, then `best`=1.
- **Threshold:** prio[1]=2, threshold[1]=2 → `irq_o[1]`=0. Set threshold to 1 → `irq_o[1]`=1 one cycle later.
- **Collision:** targets 0 and 2 both eligible for ID 1 and claim in the same cycle → `claim_id_o[0]`=1, `claim_id_o[2]`=0, `ip_o[0]`=0 next cycle.
- **Complete:** complete ID 1 while src1 still high → `ip_o[0]`=1 two edges later. Complete ID 3 when not in service, and complete ID 0 → no state change.
- **Reset:** assert `rst_i` one cycle after a claim → `ip_o`, `irq_o` and `claim_id_o` are all 0 at the next edge. With `PLIC_EDGE_TRIG_EN`, a pulse on an edge source while it is in service re-pends, and the source is claimable only after its complete.
